data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH, 32, word and address width; SETS, 8, direct-mapped lines (power of two, >=2); line = one 32-bit word.
REQ-002 Ports (name direction width meaning):
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-high
- cpu_re  input  1  load request (memory stage)
- cpu_we  input  1  store request (memory stage)
- cpu_byte_op  input  1  1 = byte access (LBU/SB), 0 = word
- cpu_addr  input  32  byte address
- cpu_wdata  input  32  store data (byte stores use bits [7:0])
- cpu_rdata  output  32  load data
- cpu_stall  output  1  hold pipeline; CPU keeps request inputs stable while high
- mem_req  output  1  backing-memory request
- mem_we  output  1  request is a write
- mem_byte_op  output  1  write is a byte write
- mem_addr  output  32  request address
- mem_wdata  output  32  write data
- mem_ack  input  1  request complete, one-cycle pulse
- mem_rdata  input  32  word read data, valid with mem_ack
- hit_count  output  32  load hits
- miss_count  output  32  load misses

Function
REQ-003 Address split: offset = addr[1:0]; index = addr[2+log2(SETS)-1:2]; tag = remaining upper bits.
REQ-004 Per line: valid bit, tag, 32-bit data word.
REQ-005 FSM states: IDLE, FILL, WRITE.
REQ-006 Load hit in IDLE (valid and tag match, cpu_we=0): cpu_rdata is driven combinationally in the same cycle, and cpu_stall=0.
REQ-007 Load data formatting: word access returns the full word; byte access returns the byte at the offset, zero-extended.
REQ-008 Load miss in IDLE: cpu_stall=1 combinationally; next state FILL; mem_addr = {addr[31:2],2'b00} is registered; mem_we=0.
REQ-009 FILL: mem_req=1 and cpu_stall=1 until mem_ack.
REQ-010 FILL, mem_ack cycle: cpu_rdata is formatted from mem_rdata and cpu_stall=0; at the clock edge the line is written (valid=1, tag, data) and the FSM returns to IDLE.
REQ-011 Store (cpu_we=1) in IDLE: write-through, no-write-allocate; cpu_stall=1; next state WRITE; mem_addr, mem_wdata and mem_byte_op are registered from the CPU inputs.
REQ-012 WRITE: mem_req=1 and mem_we=1 until mem_ack; cpu_stall=0 in the mem_ack cycle; the FSM returns to IDLE.
REQ-013 Store hit: on the WRITE-entry edge the cached word is updated; a byte store updates only the byte lane at the offset. A store miss leaves the cache unchanged.
REQ-014 cpu_re=1 and cpu_we=1 together: the store takes priority and the load is ignored.
REQ-015 mem_addr, mem_we, mem_byte_op and mem_wdata are held stable while mem_req=1; mem_req=0 in IDLE.
REQ-016 mem_ack while in IDLE is ignored.
REQ-017 No requests (cpu_re=0, cpu_we=0): no state change and cpu_stall=0.
REQ-018 hit_count increments once per load hit in IDLE; a miss followed by its refill hit counts as one miss only.
REQ-019 miss_count increments on each IDLE-to-FILL transition.
REQ-020 Both counters saturate at 32'hFFFF_FFFF.

Reset
REQ-021 While rst=1, asynchronously:
- all valid bits cleared
- state IDLE
- mem_req=0, mem_we=0, mem_byte_op=0, mem_addr=0, mem_wdata=0
- hit_count=0, miss_count=0
- cpu_stall=0, cpu_rdata=0
REQ-022 Reset during FILL or WRITE aborts the transaction: no line is written, and a later mem_ack is ignored.
REQ-023 Tag and data arrays need no reset; valid=0 masks them.

Verification
REQ-024 Cold load: re, addr=0x10, mem_ack after 3 cycles with rdata=0xDEADBEEF -> stall high 4 cycles, then cpu_rdata=0xDEADBEEF, miss_count=1; repeat load -> stall=0 same cycle, hit_count=1.
REQ-025 Byte load on cached 0xDEADBEEF at addr=0x12 -> cpu_rdata=0x000000AD, no mem_req.
REQ-026 Store-byte hit: SB 0x55 to 0x11 -> mem_req/mem_we/mem_byte_op=1, mem_addr=0x11; after ack, load 0x10 hits with 0xDEAD55EF.
REQ-027 Conflict (SETS=8): load 0x10 then load 0x30 (same index) -> second misses and evicts; load 0x10 misses again; miss_count=3.
REQ-028 Store miss to 0x44 -> one memory write; subsequent load 0x44 misses.
REQ-029 rst pulsed mid-FILL, then mem_ack -> state IDLE, mem_req=0, line invalid; reload misses.

Source files
------------

// File: rtl/data_cache_if.sv
// CPU-side and memory-side signals of the data cache bundled together.
// slave is the cache's own view; master is the view of the CPU/memory environment around it.
interface data_cache_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_re;
    logic                  cpu_we;
    logic                  cpu_byte_op;
    logic [DATA_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_stall;
    logic                  mem_req;
    logic                  mem_we;
    logic                  mem_byte_op;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [31:0]           hit_count;
    logic [31:0]           miss_count;

    modport slave (
        input  cpu_re, cpu_we, cpu_byte_op, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
        output cpu_rdata, cpu_stall, mem_req, mem_we, mem_byte_op, mem_addr, mem_wdata,
        output hit_count, miss_count
    );

    modport master (
        output cpu_re, cpu_we, cpu_byte_op, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
        input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_byte_op, mem_addr, mem_wdata,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Loads hit combinationally; misses refill from backing memory, stores always go to memory.
module data_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 8
) (
    input logic        clk,
    input logic        rst,
    data_cache_if.slave bus
);
    localparam int IndexBits = $clog2(SETS);
    localparam int TagBits   = DATA_WIDTH - 2 - IndexBits;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic [1:0]            state;
    logic [1:0]            stateNext;
    logic [SETS-1:0]       validBits;
    logic [TagBits-1:0]    tagArray  [SETS];
    logic [DATA_WIDTH-1:0] dataArray [SETS];
    logic [DATA_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memWdata;
    logic                  memByteOp;
    logic [31:0]           hitCount;
    logic [31:0]           missCount;

    logic [1:0]            offset;
    logic [IndexBits-1:0]  index;
    logic [TagBits-1:0]    tag;
    logic [IndexBits-1:0]  fillIndex;
    logic [TagBits-1:0]    fillTag;
    logic                  hit;
    logic                  storeReq;
    logic                  loadHit;
    logic                  loadMiss;
    logic                  fillDone;

    function automatic logic [DATA_WIDTH-1:0] formatLoad(input logic [DATA_WIDTH-1:0] word,
                                                         input logic byteOp,
                                                         input logic [1:0] off);
        if (byteOp) return {{(DATA_WIDTH-8){1'b0}}, word[8*off +: 8]};
        return word;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] mergeStore(input logic [DATA_WIDTH-1:0] word,
                                                         input logic [DATA_WIDTH-1:0] wdata,
                                                         input logic byteOp,
                                                         input logic [1:0] off);
        logic [DATA_WIDTH-1:0] merged;
        merged = wdata;
        if (byteOp) begin
            merged = word;
            merged[8*off +: 8] = wdata[7:0];
        end
        return merged;
    endfunction

    assign offset    = bus.cpu_addr[1:0];
    assign index     = bus.cpu_addr[2 +: IndexBits];
    assign tag       = bus.cpu_addr[DATA_WIDTH-1 -: TagBits];
    // The refill target comes from the registered request, not the live CPU address.
    assign fillIndex = memAddr[2 +: IndexBits];
    assign fillTag   = memAddr[DATA_WIDTH-1 -: TagBits];

    assign hit      = validBits[index] && (tagArray[index] == tag);
    assign storeReq = (state == IDLE) && bus.cpu_we;
    assign loadHit  = (state == IDLE) && bus.cpu_re && !bus.cpu_we && hit;
    assign loadMiss = (state == IDLE) && bus.cpu_re && !bus.cpu_we && !hit;
    assign fillDone = (state == FILL) && bus.mem_ack;

    assign bus.mem_req     = (state != IDLE);
    assign bus.mem_we      = (state == WRITE);
    assign bus.mem_byte_op = memByteOp;
    assign bus.mem_addr    = memAddr;
    assign bus.mem_wdata   = memWdata;
    assign bus.hit_count   = hitCount;
    assign bus.miss_count  = missCount;

    always_comb begin
        stateNext     = state;
        bus.cpu_stall = 1'b0;
        bus.cpu_rdata = '0;
        case (state)
            IDLE: begin
                if (bus.cpu_we) begin
                    bus.cpu_stall = 1'b1;
                    stateNext     = WRITE;
                end else if (bus.cpu_re) begin
                    if (hit) begin
                        bus.cpu_rdata = formatLoad(dataArray[index], bus.cpu_byte_op, offset);
                    end else begin
                        bus.cpu_stall = 1'b1;
                        stateNext     = FILL;
                    end
                end
            end
            FILL: begin
                if (bus.mem_ack) begin
                    bus.cpu_rdata = formatLoad(bus.mem_rdata, bus.cpu_byte_op, offset);
                    stateNext     = IDLE;
                end else begin
                    bus.cpu_stall = 1'b1;
                end
            end
            WRITE: begin
                if (bus.mem_ack) stateNext = IDLE;
                else bus.cpu_stall = 1'b1;
            end
            default: stateNext = IDLE;
        endcase
        // Reset is asynchronous, so the CPU-facing outputs are forced quiet while it is held.
        if (rst) begin
            bus.cpu_stall = 1'b0;
            bus.cpu_rdata = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            validBits <= '0;
            memAddr   <= '0;
            memWdata  <= '0;
            memByteOp <= 1'b0;
            hitCount  <= '0;
            missCount <= '0;
        end else begin
            state <= stateNext;
            if (storeReq) begin
                memAddr   <= bus.cpu_addr;
                memWdata  <= bus.cpu_wdata;
                memByteOp <= bus.cpu_byte_op;
            end else if (loadMiss) begin
                memAddr   <= {bus.cpu_addr[DATA_WIDTH-1:2], 2'b00};
                memByteOp <= 1'b0;
            end
            if (fillDone) validBits[fillIndex] <= 1'b1;
            if (loadHit && (hitCount != '1)) hitCount <= hitCount + 32'd1;
            if (loadMiss && (missCount != '1)) missCount <= missCount + 32'd1;
        end
    end

    // Tag/data storage carries no reset; the valid bits mask stale contents.
    always_ff @(posedge clk) begin
        if (fillDone) begin
            tagArray[fillIndex]  <= fillTag;
            dataArray[fillIndex] <= bus.mem_rdata;
        end else if (storeReq && hit) begin
            dataArray[index] <= mergeStore(dataArray[index], bus.cpu_wdata, bus.cpu_byte_op,
                                           offset);
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed scenarios plus randomized traffic against a reference model
// that tracks backing memory as a word map and the cache as a per-set resident word address.
module tb_data_cache;
    localparam int SETS = 8;

    logic clk = 1'b0;
    logic rst;

    data_cache_if #(.DATA_WIDTH(32)) bus ();

    data_cache #(.DATA_WIDTH(32), .SETS(SETS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    logic [31:0] memModel [int unsigned];
    logic [31:0] lineWord [SETS];
    bit          lineValid [SETS];
    int          expHits;
    int          expMisses;

    int          obsStalls;
    int          obsReqCycles;
    logic [31:0] obsRdata;
    logic [31:0] obsMemAddr;
    logic [31:0] obsMemWdata;
    logic        obsMemWe;
    logic        obsMemByteOp;
    bit          obsStable;

    function automatic logic [31:0] memWord(input logic [31:0] wa);
        if (memModel.exists(wa)) return memModel[wa];
        return (wa * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] addr, input bit bop);
        logic [31:0] w;
        w = memWord(addr >> 2);
        if (bop) return (w >> (8 * addr[1:0])) & 32'hFF;
        return w;
    endfunction

    function automatic bit refHit(input logic [31:0] addr);
        int s;
        s = int'((addr >> 2) % SETS);
        return lineValid[s] && (lineWord[s] == (addr >> 2));
    endfunction

    task automatic modelLoad(input logic [31:0] addr);
        int s;
        s = int'((addr >> 2) % SETS);
        if (refHit(addr)) begin
            expHits++;
        end else begin
            expMisses++;
            lineValid[s] = 1'b1;
            lineWord[s]  = addr >> 2;
        end
    endtask

    // Write-through keeps any resident copy equal to memory, so only memory is updated.
    task automatic modelStore(input logic [31:0] addr, input logic [31:0] wdata, input bit bop);
        logic [31:0] old, mask;
        old = memWord(addr >> 2);
        if (bop) begin
            mask = 32'hFF << (8 * addr[1:0]);
            memModel[addr >> 2] = (old & ~mask) | ((wdata & 32'hFF) << (8 * addr[1:0]));
        end else begin
            memModel[addr >> 2] = wdata;
        end
    endtask

    task automatic resetModel();
        for (int s = 0; s < SETS; s++) lineValid[s] = 1'b0;
        expHits   = 0;
        expMisses = 0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        resetModel();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drives one CPU request until cpu_stall drops, acting as memory with the given ack latency.
    task automatic access(input bit re, input bit we, input bit bop, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat);
        bit done;
        done = 1'b0;
        bus.cpu_re      = re;
        bus.cpu_we      = we;
        bus.cpu_byte_op = bop;
        bus.cpu_addr    = addr;
        bus.cpu_wdata   = wdata;
        obsStalls    = 0;
        obsReqCycles = 0;
        obsStable    = 1'b1;
        obsRdata     = '0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                if (obsReqCycles == 0) begin
                    obsMemAddr   = bus.mem_addr;
                    obsMemWdata  = bus.mem_wdata;
                    obsMemWe     = bus.mem_we;
                    obsMemByteOp = bus.mem_byte_op;
                end else if (bus.mem_addr !== obsMemAddr || bus.mem_wdata !== obsMemWdata ||
                             bus.mem_we !== obsMemWe || bus.mem_byte_op !== obsMemByteOp) begin
                    obsStable = 1'b0;
                end
                if (obsReqCycles == lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = bus.mem_we ? $urandom : memWord(bus.mem_addr >> 2);
                end
                obsReqCycles++;
            end
            #1;
            obsRdata = bus.cpu_rdata;
            if (bus.cpu_stall) obsStalls++;
            else done = 1'b1;
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
        end
        bus.cpu_re = 1'b0;
        bus.cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.cpu_re  = 1'b1;
        bus.cpu_addr = 32'h10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nChecks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_byte_op} !== 3'b000) begin
            nFails++;
            $display("FAIL reset_mem_ctrl: got %b want 000",
                     {bus.mem_req, bus.mem_we, bus.mem_byte_op});
        end
        nChecks++;
        if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
            nFails++;
            $display("FAIL reset_mem_bus: got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata);
        end
        nChecks++;
        if ({bus.hit_count, bus.miss_count} !== 64'h0) begin
            nFails++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", bus.hit_count, bus.miss_count);
        end
        nChecks++;
        if ({bus.cpu_stall, bus.cpu_rdata} !== 33'h0) begin
            nFails++;
            $display("FAIL reset_cpu: got stall %b rdata %h want 0/0", bus.cpu_stall,
                     bus.cpu_rdata);
        end
        bus.cpu_re = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();
    endtask

    task automatic test_cold_load();
        memModel[32'h10 >> 2] = 32'hDEAD_BEEF;
        modelLoad(32'h10);
        access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 3);
        nChecks++;
        if (obsStalls !== 4) begin
            nFails++;
            $display("FAIL cold_stall_cycles: got %0d want 4", obsStalls);
        end
        nChecks++;
        if (obsRdata !== 32'hDEAD_BEEF) begin
            nFails++;
            $display("FAIL cold_rdata: got %h want deadbeef", obsRdata);
        end
        nChecks++;
        if ({obsMemAddr, obsMemWe} !== {32'h10, 1'b0}) begin
            nFails++;
            $display("FAIL cold_mem_req: got addr %h we %b want 10/0", obsMemAddr, obsMemWe);
        end
        nChecks++;
        if (bus.miss_count !== 32'(expMisses)) begin
            nFails++;
            $display("FAIL cold_miss_count: got %0d want %0d", bus.miss_count, expMisses);
        end
        modelLoad(32'h10);
        access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 0);
        nChecks++;
        if (obsStalls !== 0 || obsRdata !== 32'hDEAD_BEEF) begin
            nFails++;
            $display("FAIL warm_hit: got stall %0d rdata %h want 0/deadbeef", obsStalls, obsRdata);
        end
        nChecks++;
        if ({bus.hit_count, bus.miss_count} !== {32'd1, 32'd1}) begin
            nFails++;
            $display("FAIL warm_counts: got %0d/%0d want 1/1", bus.hit_count, bus.miss_count);
        end
    endtask

    task automatic test_byte_load();
        modelLoad(32'h12);
        access(1'b1, 1'b0, 1'b1, 32'h12, 32'h0, 1);
        nChecks++;
        if (obsRdata !== 32'h0000_00AD || obsReqCycles !== 0) begin
            nFails++;
            $display("FAIL byte_load: got %h req %0d want 000000ad req 0", obsRdata, obsReqCycles);
        end
    endtask

    task automatic test_store_byte_hit();
        modelStore(32'h11, 32'hABCD_EF55, 1'b1);
        access(1'b0, 1'b1, 1'b1, 32'h11, 32'hABCD_EF55, 2);
        nChecks++;
        if ({obsMemWe, obsMemByteOp, obsMemAddr} !== {1'b1, 1'b1, 32'h11}) begin
            nFails++;
            $display("FAIL sb_mem_req: got we %b byte %b addr %h want 1/1/11", obsMemWe,
                     obsMemByteOp, obsMemAddr);
        end
        nChecks++;
        if (obsMemWdata[7:0] !== 8'h55 || obsReqCycles !== 3 || obsStalls !== 3 || !obsStable) begin
            nFails++;
            $display("FAIL sb_write: got wdata %h req %0d stall %0d stable %b want 55/3/3/1",
                     obsMemWdata[7:0], obsReqCycles, obsStalls, obsStable);
        end
        modelLoad(32'h10);
        access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1);
        nChecks++;
        if (obsRdata !== 32'hDEAD_55EF || obsStalls !== 0) begin
            nFails++;
            $display("FAIL sb_reload: got %h stall %0d want dead55ef/0", obsRdata, obsStalls);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] seq [3];
        seq = '{32'h10, 32'h30, 32'h10};
        doReset();
        for (int i = 0; i < 3; i++) begin
            modelLoad(seq[i]);
            access(1'b1, 1'b0, 1'b0, seq[i], 32'h0, 1);
            nChecks++;
            if (obsReqCycles !== 2 || obsRdata !== refLoad(seq[i], 1'b0)) begin
                nFails++;
                $display("FAIL conflict_miss%0d: got req %0d rdata %h want 2/%h", i, obsReqCycles,
                         obsRdata, refLoad(seq[i], 1'b0));
            end
        end
        nChecks++;
        if ({bus.hit_count, bus.miss_count} !== {32'd0, 32'd3}) begin
            nFails++;
            $display("FAIL conflict_counts: got %0d/%0d want 0/3", bus.hit_count, bus.miss_count);
        end
    endtask

    task automatic test_store_miss();
        logic [31:0] w;
        w = $urandom;
        modelStore(32'h44, w, 1'b0);
        access(1'b0, 1'b1, 1'b0, 32'h44, w, 1);
        nChecks++;
        if (obsReqCycles !== 2 || {obsMemWe, obsMemAddr, obsMemWdata} !== {1'b1, 32'h44, w}) begin
            nFails++;
            $display("FAIL store_miss_write: got req %0d we %b addr %h wdata %h want 2/1/44/%h",
                     obsReqCycles, obsMemWe, obsMemAddr, obsMemWdata, w);
        end
        modelLoad(32'h44);
        access(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 0);
        nChecks++;
        if (obsReqCycles !== 1 || obsRdata !== w || bus.miss_count !== 32'(expMisses)) begin
            nFails++;
            $display("FAIL store_miss_reload: got req %0d rdata %h misses %0d want 1/%h/%0d",
                     obsReqCycles, obsRdata, bus.miss_count, w, expMisses);
        end
    endtask

    task automatic test_store_priority();
        logic [31:0] w;
        w = $urandom;
        modelStore(32'h10, w, 1'b0);
        access(1'b1, 1'b1, 1'b0, 32'h10, w, 0);
        nChecks++;
        if (obsMemWe !== 1'b1 || obsReqCycles !== 1 || bus.hit_count !== 32'(expHits)) begin
            nFails++;
            $display("FAIL rw_priority: got we %b req %0d hits %0d want 1/1/%0d", obsMemWe,
                     obsReqCycles, bus.hit_count, expHits);
        end
        modelLoad(32'h10);
        access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 0);
        nChecks++;
        if (obsRdata !== w || obsStalls !== 0) begin
            nFails++;
            $display("FAIL rw_store_hit_update: got %h stall %0d want %h/0", obsRdata, obsStalls, w);
        end
    endtask

    task automatic test_idle_ack();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = $urandom;
            #1;
            nChecks++;
            if (bus.cpu_stall !== 1'b0 || bus.mem_req !== 1'b0) begin
                nFails++;
                $display("FAIL idle_ack%0d: got stall %b req %b want 0/0", i, bus.cpu_stall,
                         bus.mem_req);
            end
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
        end
        nChecks++;
        if (bus.hit_count !== 32'(expHits) || bus.miss_count !== 32'(expMisses)) begin
            nFails++;
            $display("FAIL idle_counts: got %0d/%0d want %0d/%0d", bus.hit_count,
                     bus.miss_count, expHits, expMisses);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, wdata, expData, expW, gotW;
        bit          expHit, bop;
        int          kind, lat;
        for (int n = 0; n < 300; n++) begin
            kind  = $urandom_range(0, 9);
            lat   = $urandom_range(0, 3);
            bop   = 1'($urandom_range(0, 1));
            addr  = ($urandom_range(0, 3) == 0) ? 32'hF000_0000 : 32'h0;
            addr += 32'($urandom_range(0, 15)) * 4;
            if (bop) addr += 32'($urandom_range(0, 3));
            wdata = $urandom;
            if (kind < 6) begin
                expHit  = refHit(addr);
                expData = refLoad(addr, bop);
                modelLoad(addr);
                access(1'b1, 1'b0, bop, addr, wdata, lat);
                nChecks++;
                if (obsRdata !== expData) begin
                    nFails++;
                    $display("FAIL rand_load_data@%h: got %h want %h", addr, obsRdata, expData);
                end
                nChecks++;
                if (obsReqCycles !== (expHit ? 0 : lat + 1) || obsStalls !== (expHit ? 0 : lat + 1))
                begin
                    nFails++;
                    $display("FAIL rand_load_hitmiss@%h: got req %0d stall %0d want hit=%b lat %0d",
                             addr, obsReqCycles, obsStalls, expHit, lat);
                end
            end else if (kind < 9) begin
                modelStore(addr, wdata, bop);
                access(1'b0, 1'b1, bop, addr, wdata, lat);
                expW = bop ? (wdata & 32'hFF) : wdata;
                gotW = bop ? (obsMemWdata & 32'hFF) : obsMemWdata;
                nChecks++;
                if (obsReqCycles !== lat + 1 || obsStalls !== lat + 1 || !obsStable) begin
                    nFails++;
                    $display("FAIL rand_store_timing@%h: got req %0d stall %0d stable %b want %0d",
                             addr, obsReqCycles, obsStalls, obsStable, lat + 1);
                end
                nChecks++;
                if ({obsMemWe, obsMemByteOp, obsMemAddr, gotW} !== {1'b1, bop, addr, expW}) begin
                    nFails++;
                    $display("FAIL rand_store_bus: got we %b byte %b addr %h wdata %h want 1/%b/%h/%h",
                             obsMemWe, obsMemByteOp, obsMemAddr, gotW, bop, addr, expW);
                end
            end else begin
                access(1'b0, 1'b0, bop, addr, wdata, lat);
                nChecks++;
                if (obsReqCycles !== 0 || obsStalls !== 0) begin
                    nFails++;
                    $display("FAIL rand_idle: got req %0d stall %0d want 0/0", obsReqCycles,
                             obsStalls);
                end
            end
        end
        nChecks++;
        if (bus.hit_count !== 32'(expHits) || bus.miss_count !== 32'(expMisses)) begin
            nFails++;
            $display("FAIL rand_counts: got %0d/%0d want %0d/%0d", bus.hit_count,
                     bus.miss_count, expHits, expMisses);
        end
    endtask

    task automatic test_reset_mid_fill();
        doReset();
        bus.cpu_re      = 1'b1;
        bus.cpu_we      = 1'b0;
        bus.cpu_byte_op = 1'b0;
        bus.cpu_addr    = 32'h20;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nChecks++;
        if (bus.mem_req !== 1'b1 || bus.cpu_stall !== 1'b1) begin
            nFails++;
            $display("FAIL midfill_in_fill: got req %b stall %b want 1/1", bus.mem_req,
                     bus.cpu_stall);
        end
        rst = 1'b1;
        #1;
        nChecks++;
        if (bus.mem_req !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.mem_addr !== 32'h0) begin
            nFails++;
            $display("FAIL midfill_async_rst: got req %b stall %b addr %h want 0/0/0",
                     bus.mem_req, bus.cpu_stall, bus.mem_addr);
        end
        bus.cpu_re = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        #1;
        nChecks++;
        if (bus.mem_req !== 1'b0 || bus.cpu_stall !== 1'b0) begin
            nFails++;
            $display("FAIL midfill_late_ack: got req %b stall %b want 0/0", bus.mem_req,
                     bus.cpu_stall);
        end
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        modelLoad(32'h20);
        access(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 1);
        nChecks++;
        if (obsReqCycles !== 2 || obsRdata !== refLoad(32'h20, 1'b0) ||
            bus.miss_count !== 32'd1 || bus.hit_count !== 32'd0) begin
            nFails++;
            $display("FAIL midfill_reload: got req %0d rdata %h misses %0d hits %0d want 2/%h/1/0",
                     obsReqCycles, obsRdata, bus.miss_count, bus.hit_count, refLoad(32'h20, 1'b0));
        end
    endtask

    initial begin
        bus.cpu_re      = 1'b0;
        bus.cpu_we      = 1'b0;
        bus.cpu_byte_op = 1'b0;
        bus.cpu_addr    = '0;
        bus.cpu_wdata   = '0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        rst             = 1'b1;
        test_reset();
        test_cold_load();
        test_byte_load();
        test_store_byte_hit();
        test_conflict();
        test_store_miss();
        test_store_priority();
        test_idle_ack();
        test_random();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end
endmodule
